// File: rtl/drop_controller.sv
// drop_controller
//   Move-execution stage in front of the win checker. It takes a column
//   choice and finds the landing row from per-column height counters. It
//   read-modify-writes the piece into the 8x16 board RAM, then hands the RAM
//   to the checker (check_en) and latches the verdict. It also clears the
//   board after reset and on new_game, alternates players, and detects a
//   draw after 64 moves.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   new_game         level, restart the game (highest priority)
//   drop_req         one-cycle request to drop a piece in drop_col
//   drop_col[2:0]    target column, sampled with drop_req
//   ram_r_val[15:0]  board RAM read data, valid the cycle after ram_r_en
//   check_finished   checker done; g_win / o_win are sampled with it
//   g_win, o_win     checker verdicts
//   ram_addr[2:0]    board row address (row 0 = bottom)
//   ram_r_en         RAM read strobe
//   ram_w_en         RAM write strobe
//   ram_w_val[15:0]  RAM write data
//   check_en         level; the checker owns the RAM while high
//   busy             high except in IDLE and OVER (one-cycle lag on state)
//   cur_player       0 = G to move, 1 = O to move
//   illegal          one-cycle pulse: requested column is full
//   move_done        one-cycle pulse: a move was written and checked
//   game_over        level
//   winner[1:0]      00 none, 01 G, 10 O, 11 draw
module drop_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        drop_req,
    input  logic [2:0]  drop_col,
    input  logic [15:0] ram_r_val,
    input  logic        check_finished,
    input  logic        g_win,
    input  logic        o_win,
    output logic [2:0]  ram_addr,
    output logic        ram_r_en,
    output logic        ram_w_en,
    output logic [15:0] ram_w_val,
    output logic        check_en,
    output logic        busy,
    output logic        cur_player,
    output logic        illegal,
    output logic        move_done,
    output logic        game_over,
    output logic [1:0]  winner
);

    typedef enum logic [2:0] {CLEAR, IDLE, READ, WRITE, CHECK, OVER} state_t;

    state_t      state;
    logic [2:0]  clr_row;
    logic [3:0]  height [8];
    logic [6:0]  move_cnt;
    logic [2:0]  col;
    logic [15:0] piece_mask;
    logic [15:0] piece_bits;

    // Column of the move in flight; pure data, captured on an accepted request.
    always_ff @(posedge clk) begin
        if (state == IDLE && drop_req)
            col <= drop_col;
    end

    // The row read in READ only arrives during the WRITE cycle, so the merge
    // of the new piece into that row is formed combinationally from the
    // returned data. Outside WRITE the bus carries zero, which is also the
    // value written while clearing.
    always_comb begin
        piece_mask = 16'h0003 << {col, 1'b0};
        piece_bits = (cur_player ? 16'h0002 : 16'h0001) << {col, 1'b0};
    end

    assign ram_w_val = (state == WRITE) ? ((ram_r_val & ~piece_mask) | piece_bits)
                                        : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_row    <= 3'd0;
            move_cnt   <= 7'd0;
            ram_addr   <= 3'd0;
            ram_r_en   <= 1'b0;
            ram_w_en   <= 1'b0;
            check_en   <= 1'b0;
            busy       <= 1'b1;
            cur_player <= 1'b0;
            illegal    <= 1'b0;
            move_done  <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            for (int i = 0; i < 8; i++)
                height[i] <= 4'd0;
        end else begin
            ram_r_en  <= 1'b0;
            ram_w_en  <= 1'b0;
            illegal   <= 1'b0;
            move_done <= 1'b0;
            busy      <= !(state == IDLE || state == OVER);

            if (new_game) begin
                // Abandon whatever is in flight; clearing restarts at row 0
                // for as long as new_game is held.
                state    <= CLEAR;
                clr_row  <= 3'd0;
                ram_addr <= 3'd0;
                check_en <= 1'b0;
            end else begin
                case (state)
                    CLEAR: begin
                        ram_w_en   <= 1'b1;
                        ram_addr   <= clr_row;
                        clr_row    <= clr_row + 3'd1;
                        move_cnt   <= 7'd0;
                        cur_player <= 1'b0;
                        game_over  <= 1'b0;
                        winner     <= 2'b00;
                        for (int i = 0; i < 8; i++)
                            height[i] <= 4'd0;
                        if (clr_row == 3'd7)
                            state <= IDLE;
                    end
                    IDLE: begin
                        if (drop_req) begin
                            if (height[drop_col] == 4'd8) begin
                                illegal <= 1'b1;
                            end else begin
                                ram_r_en <= 1'b1;
                                ram_addr <= height[drop_col][2:0];
                                state    <= READ;
                            end
                        end
                    end
                    READ: begin
                        ram_w_en <= 1'b1;
                        state    <= WRITE;
                    end
                    WRITE: begin
                        height[col] <= height[col] + 4'd1;
                        move_cnt    <= move_cnt + 7'd1;
                        check_en    <= 1'b1;
                        state       <= CHECK;
                    end
                    CHECK: begin
                        if (check_finished) begin
                            check_en  <= 1'b0;
                            move_done <= 1'b1;
                            if (g_win || o_win) begin
                                winner    <= {o_win, g_win};
                                game_over <= 1'b1;
                                state     <= OVER;
                            end else if (move_cnt == 7'd64) begin
                                winner    <= 2'b11;
                                game_over <= 1'b1;
                                state     <= OVER;
                            end else begin
                                cur_player <= ~cur_player;
                                state      <= IDLE;
                            end
                        end
                    end
                    OVER: ;
                    default: state <= CLEAR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_drop_controller.sv
module tb_drop_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_game;
    logic        drop_req;
    logic [2:0]  drop_col;
    logic [15:0] ram_r_val;
    logic        check_finished;
    logic        g_win;
    logic        o_win;
    logic [2:0]  ram_addr;
    logic        ram_r_en;
    logic        ram_w_en;
    logic [15:0] ram_w_val;
    logic        check_en;
    logic        busy;
    logic        cur_player;
    logic        illegal;
    logic        move_done;
    logic        game_over;
    logic [1:0]  winner;

    always #5 clk = ~clk;

    drop_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .new_game       (new_game),
        .drop_req       (drop_req),
        .drop_col       (drop_col),
        .ram_r_val      (ram_r_val),
        .check_finished (check_finished),
        .g_win          (g_win),
        .o_win          (o_win),
        .ram_addr       (ram_addr),
        .ram_r_en       (ram_r_en),
        .ram_w_en       (ram_w_en),
        .ram_w_val      (ram_w_val),
        .check_en       (check_en),
        .busy           (busy),
        .cur_player     (cur_player),
        .illegal        (illegal),
        .move_done      (move_done),
        .game_over      (game_over),
        .winner         (winner)
    );

    // Board RAM: synchronous read, filled with junk during reset so that
    // clearing is visible.
    logic [15:0] mem [8];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'hFFFF;
        end else begin
            if (ram_w_en) mem[ram_addr] <= ram_w_val;
            if (ram_r_en) ram_r_val <= mem[ram_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;

    // Expected game state.
    logic [15:0] mb [8];
    int          mh [8];
    int          mcnt;
    logic        mp;
    logic [1:0]  mw;
    logic        mover;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mb[i] = 16'h0000;
            mh[i] = 0;
        end
        mcnt  = 0;
        mp    = 1'b0;
        mw    = 2'b00;
        mover = 1'b0;
    endtask

    // Eight clear writes, then busy low, board zero, game state reset.
    task automatic clear_seq();
        for (int k = 0; k < 8; k++) begin
            step();
            check("clr_wen",  32'(ram_w_en), 1);
            check("clr_addr", 32'(ram_addr), k);
            check("clr_val",  32'(ram_w_val), 0);
            check("clr_busy", 32'(busy), 1);
        end
        step();
        check("clr_busy_low", 32'(busy), 0);
        check("clr_wen_off",  32'(ram_w_en), 0);
        for (int r = 0; r < 8; r++)
            check("clr_row_zero", 32'(mem[r]), 0);
        check("clr_player", 32'(cur_player), 0);
        check("clr_winner", 32'(winner), 0);
        check("clr_over",   32'(game_over), 0);
        model_reset();
    endtask

    task automatic do_move(input logic [2:0] c, input logic gw, input logic ow);
        logic [15:0] exp_w;
        int row;
        int ci;
        ci  = int'(c);
        row = mh[ci];
        drop_req = 1'b1;
        drop_col = c;
        step();
        drop_req = 1'b0;
        check("read_strobe", 32'(ram_r_en), 1);
        check("read_addr",   32'(ram_addr), row);
        check("illegal_low", 32'(illegal), 0);
        step();
        exp_w = mb[row];
        exp_w[2*ci +: 2] = mp ? 2'b10 : 2'b01;
        check("write_strobe", 32'(ram_w_en), 1);
        check("read_off",     32'(ram_r_en), 0);
        check("write_addr",   32'(ram_addr), row);
        check("write_val",    32'(ram_w_val), 32'(exp_w));
        mb[row] = exp_w;
        mh[ci]++;
        mcnt++;
        step();
        check("check_en_rise", 32'(check_en), 1);
        check("write_off",     32'(ram_w_en), 0);
        check("busy_move",     32'(busy), 1);
        step();
        step();
        check("check_en_hold", 32'(check_en), 1);
        check_finished = 1'b1;
        g_win = gw;
        o_win = ow;
        step();
        check_finished = 1'b0;
        g_win = 1'b0;
        o_win = 1'b0;
        if (gw || ow) begin
            mw = {ow, gw};
            mover = 1'b1;
        end else if (mcnt == 64) begin
            mw = 2'b11;
            mover = 1'b1;
        end else begin
            mp = ~mp;
        end
        check("check_en_drop", 32'(check_en), 0);
        check("move_done",     32'(move_done), 1);
        check("cur_player",    32'(cur_player), 32'(mp));
        check("winner",        32'(winner), 32'(mw));
        check("game_over",     32'(game_over), 32'(mover));
        step();
        check("move_done_pulse", 32'(move_done), 0);
        check("busy_after",      32'(busy), 0);
    endtask

    task automatic full_drop(input logic [2:0] c);
        drop_req = 1'b1;
        drop_col = c;
        step();
        drop_req = 1'b0;
        check("illegal_pulse",  32'(illegal), 1);
        check("illegal_no_rd",  32'(ram_r_en), 0);
        check("illegal_busy",   32'(busy), 0);
        step();
        check("illegal_end",    32'(illegal), 0);
        check("illegal_no_wr",  32'(ram_w_en), 0);
        check("illegal_no_rd2", 32'(ram_r_en), 0);
        check("illegal_player", 32'(cur_player), 32'(mp));
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        check("ng_check_en", 32'(check_en), 0);
        check("ng_wen",      32'(ram_w_en), 0);
        clear_seq();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        new_game = 1'b0;
        drop_req = 1'b0;
        drop_col = 3'd0;
        check_finished = 1'b0;
        g_win = 1'b0;
        o_win = 1'b0;
        model_reset();
        step();
        step();
        step();
        check("rst_addr",      32'(ram_addr), 0);
        check("rst_ren",       32'(ram_r_en), 0);
        check("rst_wen",       32'(ram_w_en), 0);
        check("rst_wval",      32'(ram_w_val), 0);
        check("rst_check_en",  32'(check_en), 0);
        check("rst_busy",      32'(busy), 1);
        check("rst_player",    32'(cur_player), 0);
        check("rst_illegal",   32'(illegal), 0);
        check("rst_move_done", 32'(move_done), 0);
        check("rst_over",      32'(game_over), 0);
        check("rst_winner",    32'(winner), 0);
        rst_n = 1'b1;
        clear_seq();

        // Two pieces stacked in column 3: G at row 0, O at row 1.
        do_move(3'd3, 1'b0, 1'b0);
        check("row0_col3", 32'(mem[0]), 32'h0040);
        do_move(3'd3, 1'b0, 1'b0);
        check("row1_col3", 32'(mem[1]), 32'h0080);
        check("player_back", 32'(cur_player), 0);

        // Fill column 0, then one more drop is illegal.
        for (int i = 0; i < 8; i++)
            do_move(3'd0, 1'b0, 1'b0);
        full_drop(3'd0);

        // new_game while the checker owns the RAM.
        drop_req = 1'b1;
        drop_col = 3'd5;
        step();
        drop_req = 1'b0;
        step();
        step();
        check("abort_check_en", 32'(check_en), 1);
        pulse_new_game();

        // G wins on the first move; later requests are ignored.
        do_move(3'd0, 1'b1, 1'b0);
        drop_req = 1'b1;
        drop_col = 3'd1;
        step();
        drop_req = 1'b0;
        check("over_no_rd",   32'(ram_r_en), 0);
        check("over_no_ill",  32'(illegal), 0);
        check("over_busy",    32'(busy), 0);
        step();
        check("over_no_rd2",  32'(ram_r_en), 0);
        check("over_no_wr",   32'(ram_w_en), 0);
        check("over_level",   32'(game_over), 1);
        check("over_winner",  32'(winner), 32'h1);
        pulse_new_game();

        // 64 moves with no win: draw.
        for (int i = 0; i < 64; i++)
            do_move(3'(i % 8), 1'b0, 1'b0);
        check("draw_winner", 32'(winner), 32'h3);
        check("draw_over",   32'(game_over), 1);
        pulse_new_game();

        // O wins with the 64th move.
        for (int i = 0; i < 64; i++)
            do_move(3'(i % 8), 1'b0, (i == 63));
        check("last_win_winner", 32'(winner), 32'h2);
        check("last_win_over",   32'(game_over), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
